// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters advanced by a pixel-rate enable,
// with sync, blanking and start pulses registered alongside the counters.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic       line_start
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_DISPLAY);
    localparam logic [9:0] V_ACT    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] x_q, x_d, y_q, y_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic       frame_start_q, frame_start_d, line_start_q, line_start_d;

    function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    // Decode from the next counter values so the registered outputs line up
    // with the registered counters in the same cycle.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;
        if (pix_en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
            hsync_d       = !in_window(x_d, HS_START, HS_END);
            vsync_d       = !in_window(y_d, VS_START, VS_END);
            video_on_d    = (x_d < H_ACT) && (y_d < V_ACT);
            line_start_d  = (x_d == '0);
            frame_start_d = (x_d == '0) && (y_d == '0);
        end
    end

    // Reset parks the counters on the last pixel so the first enable lands on (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a reduced-timing instance (16x11 frame) for frame-level
// behaviour and a default-timing instance for line-level behaviour.
module tb_vga_sync_gen;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
        logic       ls;
    } out_t;

    typedef struct {
        bit   pe;
        out_t e;
    } vec_t;

    logic       clk, rst_s, rst_d, pe_s, pe_d;
    logic       hs_s, vs_s, von_s, fs_s, ls_s, hs_d, vs_d, von_d, fs_d, ls_d;
    logic [9:0] x_s, y_s, x_d, y_d;

    int n_cmp = 0, n_fail = 0, cyc = 0;
    int mx[2], my[2];
    out_t qs[$], qd[$];

    // stats state
    bit st_en[2];
    int last_ls[2], last_fs[2], exp_ls[2], exp_fs[2];
    bit fr_en, fr_started, hs_trk, hs_in_low;
    int von_cnt, vs_cnt, hs_len;
    logic [9:0] prev_xd, prev_yd;

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u_small (
        .clk(clk), .reset(rst_s), .pix_en(pe_s), .hsync(hs_s), .vsync(vs_s),
        .video_on(von_s), .x(x_s), .y(y_s), .frame_start(fs_s), .line_start(ls_s)
    );

    vga_sync_gen u_dflt (
        .clk(clk), .reset(rst_d), .pix_en(pe_d), .hsync(hs_d), .vsync(vs_d),
        .video_on(von_d), .x(x_d), .y(y_d), .frame_start(fs_d), .line_start(ls_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL timeout: run did not complete, %0d compared / %0d mismatched", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

    function automatic out_t mk(input int xv, input int yv, input bit h, input bit v,
                                input bit vo, input bit f, input bit l);
        out_t o;
        o.x = 10'(xv); o.y = 10'(yv); o.hs = h; o.vs = v; o.von = vo; o.fs = f; o.ls = l;
        return o;
    endfunction

    function automatic out_t cur(input int k);
        if (k == 0) return mk(int'(x_s), int'(y_s), hs_s, vs_s, von_s, fs_s, ls_s);
        return mk(int'(x_d), int'(y_d), hs_d, vs_d, von_d, fs_d, ls_d);
    endfunction

    // Timing of each instance: display, front, sync, back (h then v).
    function automatic void tparams(input int k, output int hd, output int hf, output int hsw,
                                    output int ht, output int vd, output int vf,
                                    output int vsw, output int vt);
        if (k == 0) begin
            hd = 8;   hf = 2;  hsw = 3;  ht = 16;  vd = 6;   vf = 1;  vsw = 2; vt = 11;
        end else begin
            hd = 640; hf = 16; hsw = 96; ht = 800; vd = 480; vf = 10; vsw = 2; vt = 525;
        end
    endfunction

    function automatic void mreset(input int k);
        int hd, hf, hsw, ht, vd, vf, vsw, vt;
        tparams(k, hd, hf, hsw, ht, vd, vf, vsw, vt);
        mx[k] = ht - 1;
        my[k] = vt - 1;
    endfunction

    function automatic out_t mstep(input int k, input bit pe);
        int hd, hf, hsw, ht, vd, vf, vsw, vt;
        out_t o;
        tparams(k, hd, hf, hsw, ht, vd, vf, vsw, vt);
        o.fs = 1'b0;
        o.ls = 1'b0;
        if (pe) begin
            mx[k]++;
            if (mx[k] == ht) begin
                mx[k] = 0;
                my[k]++;
                if (my[k] == vt) my[k] = 0;
            end
            o.ls = (mx[k] == 0);
            o.fs = (mx[k] == 0) && (my[k] == 0);
        end
        o.x   = 10'(mx[k]);
        o.y   = 10'(my[k]);
        o.hs  = !(mx[k] >= hd + hf && mx[k] < hd + hf + hsw);
        o.vs  = !(my[k] >= vd + vf && my[k] < vd + vf + vsw);
        o.von = (mx[k] < hd) && (my[k] < vd);
        return o;
    endfunction

    task automatic chk_out(input string nm, input out_t a, input out_t e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b ls=%b, want x=%0d y=%0d hs=%b vs=%b von=%b fs=%b ls=%b",
                     nm, cyc, a.x, a.y, a.hs, a.vs, a.von, a.fs, a.ls,
                     e.x, e.y, e.hs, e.vs, e.von, e.fs, e.ls);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, a, e);
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            st_en[k] = 0; last_ls[k] = -1; last_fs[k] = -1; exp_ls[k] = 0; exp_fs[k] = 0;
        end
        fr_en = 0; fr_started = 0; hs_trk = 0; hs_in_low = 0;
        von_cnt = 0; vs_cnt = 0; hs_len = 0;
    endtask

    task automatic stats(input int k, input out_t a, input bit pe);
        if (!st_en[k]) return;
        if (a.ls) begin
            if (last_ls[k] >= 0) chk_int(k == 0 ? "ls_period_s" : "ls_period_d", cyc - last_ls[k], exp_ls[k]);
            last_ls[k] = cyc;
        end
        if (a.fs) begin
            if (last_fs[k] >= 0) chk_int(k == 0 ? "fs_period_s" : "fs_period_d", cyc - last_fs[k], exp_fs[k]);
            last_fs[k] = cyc;
        end
    endtask

    // Drive one clock of stimulus, queue the expectation, then check after the edge.
    task automatic tick(input bit ps, input bit pd, input bit use_tab, input out_t tab);
        out_t e, a_s, a_d;
        pe_s = ps;
        pe_d = pd;
        e = mstep(0, ps);
        qs.push_back(use_tab ? tab : e);
        qd.push_back(mstep(1, pd));
        @(posedge clk);
        #1;
        cyc++;
        a_s = cur(0);
        a_d = cur(1);
        chk_out("out_small", a_s, qs.pop_front());
        chk_out("out_dflt", a_d, qd.pop_front());
        stats(0, a_s, ps);
        stats(1, a_d, pd);
        if (fr_en) begin
            if (a_s.fs && ps) begin
                if (fr_started) begin
                    chk_int("frame_video_on_px", von_cnt, 48);
                    chk_int("frame_vsync_low_px", vs_cnt, 32);
                end
                fr_started = 1; von_cnt = 0; vs_cnt = 0;
            end
            if (ps && fr_started) begin
                von_cnt += int'(a_s.von);
                vs_cnt  += int'(!a_s.vs);
            end
            if (a_s.x >= 8 || a_s.y >= 6) chk_int("blank_video_on", int'(a_s.von), 0);
            if (a_s.x == 15) chk_int("hsync_at_xlast", int'(a_s.hs), 1);
            if (a_s.y == 10) chk_int("vsync_at_ylast", int'(a_s.vs), 1);
        end
        if (hs_trk) begin
            if (!pd) begin
                chk_int("x_frozen", int'(a_d.x), int'(prev_xd));
                chk_int("y_frozen", int'(a_d.y), int'(prev_yd));
            end else if (!a_d.hs) begin
                if (!hs_in_low) begin
                    chk_int("hsync_start_x", int'(a_d.x), 656);
                    hs_in_low = 1;
                    hs_len = 0;
                end
                hs_len++;
            end else if (hs_in_low) begin
                chk_int("hsync_width_ticks", hs_len, 96);
                hs_in_low = 0;
            end
        end
        prev_xd = a_d.x;
        prev_yd = a_d.y;
    endtask

    task automatic async_reset(input bit s, input bit d);
        out_t rs_s, rs_d;
        rs_s = mk(15, 10, 1, 1, 0, 0, 0);
        rs_d = mk(799, 524, 1, 1, 0, 0, 0);
        pe_s = 0;
        pe_d = 0;
        #2;
        if (s) rst_s = 1;
        if (d) rst_d = 1;
        #1;
        if (s) begin mreset(0); chk_out("rst_async_s", cur(0), rs_s); end
        if (d) begin mreset(1); chk_out("rst_async_d", cur(1), rs_d); end
        @(posedge clk);
        #1;
        if (s) chk_out("rst_hold_s", cur(0), rs_s);
        if (d) chk_out("rst_hold_d", cur(1), rs_d);
        rst_s = 0;
        rst_d = 0;
    endtask

    vec_t tab[20];
    out_t none;
    int   ls_cnt;

    initial begin
        rst_s = 0; rst_d = 0; pe_s = 0; pe_d = 0;
        none = '0;
        prev_xd = '0; prev_yd = '0;
        clear_stats();

        // Expected small-instance sequence right after reset release.
        tab[0]  = '{0, mk(15, 10, 1, 1, 0, 0, 0)};
        tab[1]  = '{1, mk(0, 0, 1, 1, 1, 1, 1)};
        tab[2]  = '{0, mk(0, 0, 1, 1, 1, 0, 0)};
        tab[3]  = '{1, mk(1, 0, 1, 1, 1, 0, 0)};
        for (int i = 4; i < 10; i++) tab[i] = '{1, mk(i - 2, 0, 1, 1, 1, 0, 0)};
        tab[10] = '{1, mk(8, 0, 1, 1, 0, 0, 0)};
        tab[11] = '{1, mk(9, 0, 1, 1, 0, 0, 0)};
        tab[12] = '{1, mk(10, 0, 0, 1, 0, 0, 0)};
        tab[13] = '{0, mk(10, 0, 0, 1, 0, 0, 0)};
        tab[14] = '{1, mk(11, 0, 0, 1, 0, 0, 0)};
        tab[15] = '{1, mk(12, 0, 0, 1, 0, 0, 0)};
        tab[16] = '{1, mk(13, 0, 1, 1, 0, 0, 0)};
        tab[17] = '{1, mk(14, 0, 1, 1, 0, 0, 0)};
        tab[18] = '{1, mk(15, 0, 1, 1, 0, 0, 0)};
        tab[19] = '{1, mk(0, 1, 1, 1, 1, 0, 1)};

        async_reset(1, 1);
        for (int i = 0; i < 20; i++) tick(tab[i].pe, 0, 1, tab[i].e);

        // Small instance, continuous enable: frame/line periods and per-frame counts.
        clear_stats();
        st_en[0] = 1; exp_ls[0] = 16; exp_fs[0] = 176; fr_en = 1;
        for (int i = 0; i < 3 * 176; i++) tick(1, 0, 0, none);

        // Default instance, continuous enable: 800-clk line period.
        clear_stats();
        st_en[1] = 1; exp_ls[1] = 800;
        for (int i = 0; i < 1700; i++) tick(0, 1, 0, none);

        // Default instance, 1-of-4 enable: hsync window in ticks, counters frozen between ticks.
        clear_stats();
        st_en[1] = 1; exp_ls[1] = 3200; hs_trk = 1;
        for (int i = 0; i < 10000; i++) tick(0, (i % 4) == 0, 0, none);

        // Small instance: reset inside both sync pulses.
        clear_stats();
        for (int i = 0; i < 400 && !(mx[0] == 11 && my[0] == 8); i++) tick(1, 0, 0, none);
        chk_int("pre_rst_hsync_low_s", int'(hs_s), 0);
        chk_int("pre_rst_vsync_low_s", int'(vs_s), 0);
        async_reset(1, 0);
        tick(1, 0, 0, none);
        chk_int("post_rst_fs_s", int'(fs_s), 1);
        chk_int("post_rst_ls_s", int'(ls_s), 1);
        for (int i = 0; i < 5; i++) tick(1, 0, 0, none);

        // Default instance: reset at x=700 (mid hsync).
        async_reset(0, 1);
        for (int i = 0; i < 1000 && mx[1] != 700; i++) tick(0, 1, 0, none);
        chk_int("pre_rst_x_d", int'(x_d), 700);
        chk_int("pre_rst_hsync_low_d", int'(hs_d), 0);
        async_reset(0, 1);
        tick(0, 1, 0, none);
        chk_int("post_rst_x_d", int'(x_d), 0);
        chk_int("post_rst_fs_d", int'(fs_d), 1);

        // Small instance: enable held low for 50 clks across the line wrap.
        for (int i = 0; i < 40 && mx[0] != 15; i++) tick(1, 0, 0, none);
        ls_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick(0, 0, 0, none);
            ls_cnt += int'(ls_s) + int'(fs_s);
        end
        chk_int("hold_no_pulses", ls_cnt, 0);
        tick(1, 0, 0, none);
        ls_cnt = int'(ls_s);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, none);
            ls_cnt += int'(ls_s);
        end
        chk_int("hold_single_ls", ls_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
